// File: rtl/demux4_deser.sv
// 1:4 bit-serial deserializer: bits fill slots 0..3 LSB-first, and each completed
// nibble is held on a valid/ready output until the consumer takes it.
module demux4_deser #(
  parameter int NSLOT = 4,
  parameter int SW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          din_i,
  input  logic          din_valid_i,
  output logic          din_ready_o,
  input  logic          flush_i,
  output logic [3:0]    dout_o,
  output logic          dout_valid_o,
  input  logic          out_ready_i,
  output logic [SW-1:0] sel_o,
  output logic [3:0]    sel_onehot_o
);

  logic [SW-1:0] sel_q, sel_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [3:0]    dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;

  logic last_slot_s;
  logic stall_s;
  logic acc_s;
  logic complete_s;
  logic consume_s;

  // Only the word-completing bit can stall, and only while an unconsumed word is held.
  assign last_slot_s = (sel_q == 2'd3);
  assign stall_s     = last_slot_s & dout_valid_q & ~out_ready_i;
  assign acc_s       = din_valid_i & ~stall_s & ~flush_i;
  assign complete_s  = acc_s & last_slot_s;
  assign consume_s   = dout_valid_q & out_ready_i;

  // Next-state for the slot counter, shadow bits and output word.
  always_comb begin
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (flush_i) begin
      sel_d = 2'd0;
    end else if (acc_s) begin
      case (sel_q)
        2'd0: begin
          shadow_d[0] = din_i;
          sel_d       = 2'd1;
        end
        2'd1: begin
          shadow_d[1] = din_i;
          sel_d       = 2'd2;
        end
        2'd2: begin
          shadow_d[2] = din_i;
          sel_d       = 2'd3;
        end
        2'd3: begin
          dout_d = {din_i, shadow_q};
          sel_d  = 2'd0;
        end
        default: begin
          sel_d = 2'd0;
        end
      endcase
    end else begin
      sel_d = sel_q;
    end

    // A completing word wins over consumption so back-to-back words leave no bubble.
    if (complete_s) begin
      dout_valid_d = 1'b1;
    end else if (consume_s) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q        <= 2'd0;
      shadow_q     <= 3'b000;
      dout_q       <= 4'b0000;
      dout_valid_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Slot decode driven from the sel register only.
  always_comb begin
    sel_onehot_o = 4'b0001;
    case (sel_q)
      2'd0:    sel_onehot_o = 4'b0001;
      2'd1:    sel_onehot_o = 4'b0010;
      2'd2:    sel_onehot_o = 4'b0100;
      2'd3:    sel_onehot_o = 4'b1000;
      default: sel_onehot_o = 4'b0001;
    endcase
  end

  assign din_ready_o  = ~stall_s;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign sel_o        = sel_q;

endmodule

// File: tb/tb_demux4_deser.sv
// Randomised and directed checks of demux4_deser against a word-level reference model.
module tb_demux4_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       flush;
  logic [3:0] dout;
  logic       dout_valid;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] sel_onehot;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count of bits collected, the bits themselves, held word.
  int m_cnt;
  int m_bits[4];
  int m_word;
  bit m_valid;
  int recv_q[$];
  int sent_q[$];

  demux4_deser #(.NSLOT(4), .SW(2)) dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid),
    .din_ready_o(din_ready), .flush_i(flush), .dout_o(dout),
    .dout_valid_o(dout_valid), .out_ready_i(out_ready), .sel_o(sel),
    .sel_onehot_o(sel_onehot)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_word  = 0;
    m_valid = 0;
  endtask

  // One clock cycle: inputs applied just after a rising edge, outputs checked at the
  // falling edge, model advanced at the next rising edge.
  task automatic step(input bit d, input bit dv, input bit ordy, input bit fl, output bit taken);
    bit exp_ready, acc, complete, consume, dut_v;
    int dut_d;
    din = d; din_valid = dv; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_ready = !(m_cnt == 3 && m_valid && !ordy);
    check_eq("sel", 32'(sel), 32'(m_cnt));
    check_eq("sel_onehot", 32'(sel_onehot), 32'(1 << m_cnt));
    check_eq("din_ready", 32'(din_ready), 32'(exp_ready));
    check_eq("dout_valid", 32'(dout_valid), 32'(m_valid));
    check_eq("dout", 32'(dout), 32'(m_word));
    dut_v = dout_valid;
    dut_d = int'(dout);
    @(posedge clk);
    acc      = dv && exp_ready && !fl;
    complete = acc && (m_cnt == 3);
    consume  = m_valid && ordy;
    if (dut_v && ordy) recv_q.push_back(dut_d);
    if (fl) begin
      m_cnt = 0;
    end else if (acc) begin
      m_bits[m_cnt] = int'(d);
      if (m_cnt == 3) begin
        m_word = m_bits[0] + 2 * m_bits[1] + 4 * m_bits[2] + 8 * m_bits[3];
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
    if (complete) m_valid = 1;
    else if (consume) m_valid = 0;
    taken = acc;
    #1;
  endtask

  task automatic send_bits(input logic [3:0] bits, input int n, input bit ordy);
    bit tk;
    for (int i = 0; i < n; i++) step(bits[i], 1'b1, ordy, 1'b0, tk);
  endtask

  initial begin
    bit tk;
    int bit_idx;
    int cyc;
    logic [3:0] w;

    rst = 1'b1; din = 1'b0; din_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_onehot", 32'(sel_onehot), 32'd1);
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_valid", 32'(dout_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready", 32'(din_ready), 32'd1);

    // Reset mid-word, asserted between edges.
    send_bits(4'b0011, 2, 1'b1);
    check_eq("mid_sel_pre", 32'(sel), 32'd2);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_sel", 32'(sel), 32'd0);
    check_eq("midrst_onehot", 32'(sel_onehot), 32'd1);
    check_eq("midrst_dout", 32'(dout), 32'd0);
    check_eq("midrst_valid", 32'(dout_valid), 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic word 1,0,1,1 -> 1101.
    send_bits(4'b1101, 4, 1'b1);
    check_eq("basic_dout", 32'(dout), 32'hD);
    check_eq("basic_valid", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, tk);
    check_eq("basic_one_cycle", 32'(dout_valid), 32'd0);

    // Back-to-back with a gap after the second bit.
    send_bits(4'b0100, 2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, tk);
    check_eq("gap_sel", 32'(sel), 32'd2);
    step(1'b1, 1'b1, 1'b1, 1'b0, tk);
    step(1'b0, 1'b1, 1'b1, 1'b0, tk);
    check_eq("gap_word1", 32'(dout), 32'h4);
    send_bits(4'b1111, 4, 1'b1);
    check_eq("gap_word2", 32'(dout), 32'hF);
    step(1'b0, 1'b0, 1'b1, 1'b0, tk);

    // Backpressure: held word, then stalled completing bit.
    send_bits(4'b1001, 4, 1'b0);
    check_eq("bp_dout", 32'(dout), 32'h9);
    send_bits(4'b0110, 3, 1'b0);
    check_eq("bp_sel3", 32'(sel), 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, tk);
    check_eq("bp_stall_taken", 32'(tk), 32'd0);
    check_eq("bp_hold", 32'(dout), 32'h9);
    step(1'b0, 1'b1, 1'b1, 1'b0, tk);
    check_eq("bp_swap_dout", 32'(dout), 32'h6);
    check_eq("bp_swap_valid", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, tk);

    // Flush drops the partial word but keeps a held word.
    send_bits(4'b0101, 4, 1'b0);
    send_bits(4'b0011, 2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, tk);
    check_eq("flush_sel", 32'(sel), 32'd0);
    check_eq("flush_held", 32'(dout), 32'h5);
    check_eq("flush_held_v", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, tk);
    send_bits(4'b1000, 4, 1'b1);
    check_eq("flush_next", 32'(dout), 32'h8);
    step(1'b0, 1'b0, 1'b1, 1'b0, tk);

    // Randomised stream of 32 words with random valid/ready.
    recv_q.delete();
    for (int i = 0; i < 32; i++) sent_q.push_back(int'($urandom_range(15, 0)));
    bit_idx = 0;
    cyc = 0;
    while ((bit_idx < 128 || m_valid) && cyc < 3000) begin
      w = 4'(sent_q[bit_idx / 4 < 32 ? bit_idx / 4 : 31]);
      step(bit_idx < 128 ? w[bit_idx % 4] : 1'b0,
           bit_idx < 128 && ($urandom_range(3, 0) != 0),
           bit_idx >= 128 || ($urandom_range(2, 0) != 0),
           1'b0, tk);
      if (tk) bit_idx++;
      cyc++;
    end
    check_eq("rand_done", 32'(cyc < 3000), 32'd1);
    check_eq("rand_count", 32'(recv_q.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      if (i < recv_q.size()) check_eq("rand_word", 32'(recv_q[i]), 32'(sent_q[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
